joypad_port: RTL and testbench

Background controller poller and CPU-facing read port for the two standard NES pads at $4016/$4017. It sits directly downstream of the 2A03 CPU core and consumes the CPU's `addr4016w` strobe outputs and its `naddr4016r`/`naddr4017r` read selects. It autonomously clocks both external serial pads, keeps a committed 8-button snapshot per pad, and returns serial bits on `cpu_data` exactly as the console's $4016/$4017 registers do.

---
 rtl/joypad_port.sv | 159 +++++++++++++++
 tb/tb_joypad_port.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/joypad_port.sv
// joypad_port: background poller for the two NES pads plus the CPU-facing
// $4016/$4017 serial read registers.
module joypad_port #(
  parameter int unsigned PULSE_CYCLES = 6,
  parameter int unsigned POLL_GAP     = 1024,
  parameter logic [7:0]  OPEN_BUS     = 8'h40
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] addr4016w,
  input  logic       naddr4016r,
  input  logic       naddr4017r,
  input  logic       pad1_data,
  input  logic       pad2_data,
  output logic [7:0] cpu_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons1,
  output logic [7:0] buttons2,
  output logic       frame_done
);

  localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST   = 16'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_CLKHI  = 3'd4,
    ST_COMMIT = 3'd5
  } state_t;

  state_t      state_r, state_s;
  logic [15:0] cnt_r;
  logic [2:0]  k_r;
  logic [1:0]  sync1_r, sync2_r;
  logic [7:0]  asm1_r, asm2_r;
  logic [7:0]  rd1_r, rd2_r;
  logic        sel1_r, sel2_r;
  logic        strobe_s;
  logic        unused_addr_s;

  assign strobe_s      = addr4016w[0];
  assign unused_addr_s = ^addr4016w[2:1];

  // Two-flop synchronizers for the asynchronous pad data lines (idle high).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_r <= 2'b11;
      sync2_r <= 2'b11;
    end else begin
      sync1_r <= {sync1_r[0], pad1_data};
      sync2_r <= {sync2_r[0], pad2_data};
    end
  end

  // Poll FSM next-state logic; every state leaves itself, so the counter
  // only ever counts within a single visit.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cnt_r == GAP_LAST) state_s = ST_LATCH;
        else                   state_s = ST_IDLE;
      end
      ST_LATCH: begin
        if (cnt_r == PULSE_LAST) state_s = ST_SETTLE;
        else                     state_s = ST_LATCH;
      end
      ST_SETTLE: begin
        if (cnt_r == PULSE_LAST) state_s = ST_SAMPLE;
        else                     state_s = ST_SETTLE;
      end
      ST_SAMPLE: begin
        if (k_r == 3'd7) state_s = ST_COMMIT;
        else             state_s = ST_CLKHI;
      end
      ST_CLKHI: begin
        if (cnt_r == PULSE_LAST) state_s = ST_SETTLE;
        else                     state_s = ST_CLKHI;
      end
      ST_COMMIT: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Poll FSM state, interval counter, bit capture and snapshot commit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 16'd0;
      k_r        <= 3'd0;
      asm1_r     <= 8'h00;
      asm2_r     <= 8'h00;
      buttons1   <= 8'h00;
      buttons2   <= 8'h00;
      pad_latch  <= 1'b0;
      pad_clk    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_s != state_r) cnt_r <= 16'd0;
      else                    cnt_r <= cnt_r + 16'd1;
      pad_latch  <= (state_s == ST_LATCH);
      pad_clk    <= (state_s == ST_CLKHI);
      frame_done <= (state_r == ST_COMMIT);
      case (state_r)
        ST_SAMPLE: begin
          // Pads drive active-low data; store 1 = pressed.
          asm1_r[k_r] <= ~sync1_r[1];
          asm2_r[k_r] <= ~sync2_r[1];
          if (k_r == 3'd7) k_r <= k_r;
          else             k_r <= k_r + 3'd1;
        end
        ST_COMMIT: begin
          buttons1 <= asm1_r;
          buttons2 <= asm2_r;
          k_r      <= 3'd0;
        end
        default: begin
        end
      endcase
    end
  end

  // Read shift registers: strobe reloads every cycle, otherwise a rising
  // read select shifts in a 1 so reads past the eighth return 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel1_r <= 1'b1;
      sel2_r <= 1'b1;
      rd1_r  <= 8'h00;
      rd2_r  <= 8'h00;
    end else begin
      sel1_r <= naddr4016r;
      sel2_r <= naddr4017r;
      if (strobe_s) begin
        rd1_r <= buttons1;
        rd2_r <= buttons2;
      end else begin
        if (naddr4016r && !sel1_r) rd1_r <= {1'b1, rd1_r[7:1]};
        else                       rd1_r <= rd1_r;
        if (naddr4017r && !sel2_r) rd2_r <= {1'b1, rd2_r[7:1]};
        else                       rd2_r <= rd2_r;
      end
    end
  end

  // Combinational read data; $4016 wins when both selects are low.
  always_comb begin
    cpu_data = 8'h00;
    if (!naddr4016r)      cpu_data = {OPEN_BUS[7:1], rd1_r[0]};
    else if (!naddr4017r) cpu_data = {OPEN_BUS[7:1], rd2_r[0]};
    else                  cpu_data = 8'h00;
  end

endmodule

// File: tb/tb_joypad_port.sv
// Randomized self-checking bench for joypad_port with a behavioural pad model
// and a queue-based model of the CPU read registers.
module tb_joypad_port;

  localparam int PC = 4;
  localparam int PG = 16;
  localparam int PERIOD = 16 * PC + 9 + PG;
  localparam logic [7:0] OB = 8'h40;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] addr4016w;
  logic       naddr4016r, naddr4017r;
  logic       pad1_data, pad2_data;
  logic [7:0] cpu_data, buttons1, buttons2;
  logic       pad_latch, pad_clk, frame_done;

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0] pat1 = 8'h00, pat2 = 8'h00;
  logic [7:0] sr1 = 8'h00, sr2 = 8'h00;
  logic       pclk_q = 1'b0;
  logic [7:0] exp_b1, exp_b2;
  bit         q1[$];
  bit         q2[$];
  bit         strobe_held = 1'b0;

  joypad_port #(.PULSE_CYCLES(PC), .POLL_GAP(PG), .OPEN_BUS(OB)) dut (
    .clock(clock), .reset(reset), .addr4016w(addr4016w),
    .naddr4016r(naddr4016r), .naddr4017r(naddr4017r),
    .pad1_data(pad1_data), .pad2_data(pad2_data), .cpu_data(cpu_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk), .buttons1(buttons1),
    .buttons2(buttons2), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  // Pad model: 4021-style shift register, loads while latch high, shifts on pad_clk rise.
  always @(posedge clock) begin
    pclk_q <= pad_clk;
    if (pad_latch) begin
      sr1 <= pat1;
      sr2 <= pat2;
    end else if (pad_clk && !pclk_q) begin
      sr1 <= {1'b0, sr1[7:1]};
      sr2 <= {1'b0, sr2[7:1]};
    end
  end
  assign pad1_data = ~sr1[0];
  assign pad2_data = ~sr2[0];

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit pop1();
    if (q1.size() > 0) return q1.pop_front();
    return 1'b1;
  endfunction

  function automatic bit pop2();
    if (q2.size() > 0) return q2.pop_front();
    return 1'b1;
  endfunction

  task automatic reload_model();
    q1.delete();
    q2.delete();
    for (int i = 0; i < 8; i++) begin
      q1.push_back(exp_b1[i]);
      q2.push_back(exp_b2[i]);
    end
  endtask

  task automatic wait_frame(output int cyc);
    cyc = 0;
    do begin
      @(posedge clock);
      #1;
      cyc++;
    end while (!frame_done && cyc < 400);
    if (!frame_done) check_val("frame_timeout", {15'd0, frame_done}, 16'd1);
  endtask

  task automatic strobe_pulse();
    @(negedge clock);
    addr4016w = 3'b001;
    @(negedge clock);
    addr4016w = 3'b000;
    reload_model();
  endtask

  task automatic do_read(input bit p1, input bit p2);
    bit b1, b2;
    logic [7:0] exp;
    b1 = 1'b1;
    b2 = 1'b1;
    @(negedge clock);
    naddr4016r = !p1;
    naddr4017r = !p2;
    #1;
    if (strobe_held) begin
      b1 = exp_b1[0];
      b2 = exp_b2[0];
    end else begin
      if (p1) b1 = pop1();
      if (p2) b2 = pop2();
    end
    exp = p1 ? (OB | {7'd0, b1}) : (OB | {7'd0, b2});
    check_val(p1 ? "rd4016" : "rd4017", {8'd0, cpu_data}, {8'd0, exp});
    @(negedge clock);
    naddr4016r = 1'b1;
    naddr4017r = 1'b1;
  endtask

  // From a reset release at a negedge: latch edge, latch/clk width, clk count, commit edge.
  task automatic check_first_poll(input string tag);
    int tot, latch_at, latch_w, clk_at, clk_w, nclk;
    logic lat_q, clk_q;
    tot = 0; latch_at = 0; latch_w = 0; clk_at = 0; clk_w = 0; nclk = 0;
    lat_q = 1'b0; clk_q = 1'b0;
    while (tot < 400) begin
      @(posedge clock);
      #1;
      tot++;
      if (pad_latch && !lat_q) latch_at = tot;
      if (!pad_latch && lat_q && latch_w == 0) latch_w = tot - latch_at;
      if (pad_clk && !clk_q) begin
        nclk++;
        if (clk_at == 0) clk_at = tot;
      end
      if (!pad_clk && clk_q && clk_w == 0) clk_w = tot - clk_at;
      lat_q = pad_latch;
      clk_q = pad_clk;
      if (frame_done) break;
    end
    check_val({tag, "_latch_edge"}, 16'(latch_at), 16'(PG));
    check_val({tag, "_latch_width"}, 16'(latch_w), 16'(PC));
    check_val({tag, "_clk_width"}, 16'(clk_w), 16'(PC));
    check_val({tag, "_clk_pulses"}, 16'(nclk), 16'd7);
    check_val({tag, "_frame_edge"}, 16'(tot), 16'(PG + PC + 8 * (PC + 1) + 7 * PC + 1));
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    addr4016w = 3'b000;
    naddr4016r = 1'b1;
    naddr4017r = 1'b1;
    pat1 = 8'hA5;
    pat2 = 8'h3C;

    // Reset state
    repeat (2) @(negedge clock);
    check_val("rst_latch", {15'd0, pad_latch}, 16'd0);
    check_val("rst_clk", {15'd0, pad_clk}, 16'd0);
    check_val("rst_fd", {15'd0, frame_done}, 16'd0);
    check_val("rst_btn", {buttons1, buttons2}, 16'h0000);
    check_val("rst_cpu_idle", {8'd0, cpu_data}, 16'h0000);
    naddr4016r = 1'b0;
    #1;
    check_val("rst_cpu_rd1", {8'd0, cpu_data}, {8'd0, OB});
    naddr4016r = 1'b1;
    @(negedge clock);
    reset = 1'b0;

    // First poll timing and snapshot capture
    check_first_poll("poll1");
    check_val("snap_b1", {8'd0, buttons1}, 16'h00A5);
    check_val("snap_b2", {8'd0, buttons2}, 16'h003C);
    exp_b1 = 8'hA5;
    exp_b2 = 8'h3C;
    wait_frame(cyc);
    check_val("poll_period", 16'(cyc), 16'(PERIOD));

    // Strobe then 10 reads of $4016
    strobe_pulse();
    for (int i = 0; i < 10; i++) do_read(1'b1, 1'b0);

    // Strobe held high: reads keep returning bit 0
    @(negedge clock);
    addr4016w = 3'b001;
    strobe_held = 1'b1;
    for (int i = 0; i < 5; i++) do_read(1'b1, 1'b0);
    strobe_held = 1'b0;
    @(negedge clock);
    addr4016w = 3'b000;
    reload_model();
    do_read(1'b1, 1'b0);

    // Commit mid-sequence does not disturb the read registers
    wait_frame(cyc);
    pat1 = 8'h00;
    pat2 = 8'($urandom_range(1, 255));
    strobe_pulse();
    for (int i = 0; i < 3; i++) do_read(1'b1, 1'b0);
    wait_frame(cyc);
    check_val("commit_b1", {8'd0, buttons1}, 16'h0000);
    check_val("commit_b2", {8'd0, buttons2}, {8'd0, pat2});
    exp_b1 = pat1;
    exp_b2 = pat2;
    for (int i = 0; i < 6; i++) begin
      do_read(1'b1, 1'b0);
      do_read(1'b0, 1'b1);
    end

    // Randomized rounds: random pad patterns, random read/strobe traffic
    for (int r = 0; r < 4; r++) begin
      wait_frame(cyc);
      pat1 = 8'($urandom_range(1, 255));
      pat2 = 8'($urandom_range(0, 255));
      wait_frame(cyc);
      check_val("rand_b1", {8'd0, buttons1}, {8'd0, pat1});
      check_val("rand_b2", {8'd0, buttons2}, {8'd0, pat2});
      exp_b1 = pat1;
      exp_b2 = pat2;
      strobe_pulse();
      for (int j = 0; j < 14; j++) begin
        case ($urandom_range(0, 4))
          0: strobe_pulse();
          1: do_read(1'b1, 1'b1);
          2: do_read(1'b0, 1'b1);
          default: do_read(1'b1, 1'b0);
        endcase
      end
    end

    // Reset mid-poll during a clock-high pulse
    cyc = 0;
    do begin
      @(posedge clock);
      #1;
      cyc++;
    end while (!pad_clk && cyc < 400);
    check_val("midrst_reach_clkhi", {15'd0, pad_clk}, 16'd1);
    #2;
    reset = 1'b1;
    #1;
    check_val("midrst_clk", {15'd0, pad_clk}, 16'd0);
    check_val("midrst_latch", {15'd0, pad_latch}, 16'd0);
    check_val("midrst_b1", {8'd0, buttons1}, 16'h0000);
    check_val("midrst_fd", {15'd0, frame_done}, 16'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_first_poll("poll2");
    check_val("poll2_b1", {8'd0, buttons1}, {8'd0, pat1});
    check_val("poll2_b2", {8'd0, buttons2}, {8'd0, pat2});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
